// File: rtl/adex_spike_monitor.sv
// Spike observer: ISI capture, per-window spike count and firing-pattern class; results 1 cycle after the event.
// No backpressure: outputs are registered pulses/levels, enable low freezes everything.
module adex_spike_monitor #(
  parameter int ISI_W      = 12,
  parameter int WIN_CYCLES = 1000,
  parameter int BURST_ISI  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             spike_in,
  input  logic [1:0]       rd_sel,
  output logic [7:0]       rd_data,
  output logic             isi_valid,
  output logic [ISI_W-1:0] isi_last,
  output logic [7:0]       spike_count,
  output logic [1:0]       pattern,
  output logic             win_done
);

  localparam int WIN_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [ISI_W-1:0] ISI_MAX   = '1;
  localparam logic [ISI_W:0]   BURST_THR = (ISI_W+1)'(BURST_ISI);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;

  state_t           state, state_nxt;
  logic             spike_prev;
  logic             evt;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_prev;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       win_spikes;
  logic [3:0]       n_short, n_long, n_reg;

  logic             cls_en, is_short, is_long;
  logic             inc_short, inc_long, inc_reg;
  logic [ISI_W:0]   long_thr;
  logic [3:0]       n_short_nxt, n_long_nxt, n_reg_nxt;
  logic [7:0]       spikes_nxt;
  logic [1:0]       pattern_nxt;
  logic             win_term;

  assign evt = spike_in & ~spike_prev & enable;

  // Edge history follows the input even through reset/clear.
  always_ff @(posedge clk) begin
    spike_prev <= spike_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (evt) begin
      case (state)
        IDLE:    state_nxt = FIRST;
        FIRST:   state_nxt = TRACK;
        default: state_nxt = TRACK;
      endcase
    end
  end

  always_comb begin
    cls_en    = evt && (state != IDLE);
    long_thr  = {1'b0, isi_prev} + {3'b000, isi_prev[ISI_W-1:2]};
    is_short  = {1'b0, isi_cnt} < BURST_THR;
    is_long   = {1'b0, isi_cnt} > long_thr;
    // The ISI closing FIRST has no predecessor, so it is never "long".
    inc_short = cls_en && is_short;
    inc_long  = cls_en && !is_short && (state == TRACK) && is_long;
    inc_reg   = cls_en && !inc_short && !inc_long;

    n_short_nxt = (inc_short && n_short != 4'hf) ? n_short + 4'd1 : n_short;
    n_long_nxt  = (inc_long  && n_long  != 4'hf) ? n_long  + 4'd1 : n_long;
    n_reg_nxt   = (inc_reg   && n_reg   != 4'hf) ? n_reg   + 4'd1 : n_reg;
    spikes_nxt  = (evt && win_spikes != 8'hff) ? win_spikes + 8'd1 : win_spikes;

    if (spikes_nxt < 8'd2)          pattern_nxt = 2'd0;
    else if (n_short_nxt >= 4'd2)   pattern_nxt = 2'd3;
    else if (n_long_nxt > n_reg_nxt) pattern_nxt = 2'd2;
    else                            pattern_nxt = 2'd1;

    win_term = enable && (win_cnt == WIN_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      isi_cnt     <= '0;
      isi_prev    <= '0;
      isi_last    <= '0;
      isi_valid   <= 1'b0;
      win_cnt     <= '0;
      win_spikes  <= '0;
      n_short     <= '0;
      n_long      <= '0;
      n_reg       <= '0;
      spike_count <= '0;
      pattern     <= '0;
      win_done    <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      win_done  <= 1'b0;
      if (enable) begin
        if (evt)
          isi_cnt <= {{(ISI_W-1){1'b0}}, 1'b1};
        else if (state != IDLE && isi_cnt != ISI_MAX)
          isi_cnt <= isi_cnt + 1'b1;

        if (cls_en) begin
          isi_last  <= isi_cnt;
          isi_prev  <= isi_cnt;
          isi_valid <= 1'b1;
        end

        if (win_term) begin
          win_cnt     <= '0;
          spike_count <= spikes_nxt;
          pattern     <= pattern_nxt;
          win_done    <= 1'b1;
          win_spikes  <= '0;
          n_short     <= '0;
          n_long      <= '0;
          n_reg       <= '0;
        end else begin
          win_cnt    <= win_cnt + 1'b1;
          win_spikes <= spikes_nxt;
          n_short    <= n_short_nxt;
          n_long     <= n_long_nxt;
          n_reg      <= n_reg_nxt;
        end
      end
    end
  end

  always_comb begin
    case (rd_sel)
      2'd0:    rd_data = spike_count;
      2'd1:    rd_data = isi_last[ISI_W-1 -: 8];
      2'd2:    rd_data = {2'b00, n_short, pattern};
      default: rd_data = isi_last[7:0];
    endcase
  end

endmodule

// File: tb/tb_adex_spike_monitor.sv
// Bench for adex_spike_monitor: table of per-window firing scenarios plus hand sequences for
// reset, ISI saturation, mid-window clear and enable gating; ISIs checked through a queue.
module tb_adex_spike_monitor;

  logic        clk = 1'b0;
  logic        rst_n, enable, clear, spike_in;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;
  logic        isi_valid;
  logic [11:0] isi_last;
  logic [7:0]  spike_count;
  logic [1:0]  pattern;
  logic        win_done;

  adex_spike_monitor #(.ISI_W(12), .WIN_CYCLES(1000), .BURST_ISI(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .spike_in(spike_in),
    .rd_sel(rd_sel), .rd_data(rd_data), .isi_valid(isi_valid), .isi_last(isi_last),
    .spike_count(spike_count), .pattern(pattern), .win_done(win_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               n;
    logic [4:0][15:0] e;
    int               hold;
    int               exp_cnt;
    int               exp_pat;
    int               exp_nshort;
  } scn_t;

  scn_t scn[5];
  int   exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   wins  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and pop the scoreboard on isi_valid.
  task automatic step();
    @(posedge clk);
    #1;
    if (isi_valid) begin
      if (exp_q.size() == 0) chk("isi_spurious", int'(isi_last), -1);
      else                   chk("isi_last", int'(isi_last), exp_q.pop_front());
    end
    if (win_done) wins++;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    spike_in = 1'b0;
    step();
    clear = 1'b0;
    wins  = 0;
  endtask

  function automatic logic spike_level(input scn_t s, input int c);
    for (int k = 0; k < s.n; k++)
      if (c >= int'(s.e[k]) && c < int'(s.e[k]) + s.hold) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    scn[0] = '{"none",      1, {16'd0, 16'd0, 16'd0, 16'd0, 16'd50},     1, 1, 0, -1};
    scn[1] = '{"adapting",  4, {16'd0, 16'd225, 16'd170, 16'd130, 16'd100}, 1, 4, 2, -1};
    scn[2] = '{"bursting",  5, {16'd304, 16'd300, 16'd18, 16'd14, 16'd10},  3, 5, 3, 3};
    scn[3] = '{"boundary",  2, {16'd0, 16'd0, 16'd0, 16'd999, 16'd500},  1, 2, 1, -1};
    scn[4] = '{"tonic",     4, {16'd0, 16'd160, 16'd110, 16'd60, 16'd10}, 1, 4, 1, -1};

    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; spike_in = 1'b0; rd_sel = 2'd0;

    // Reset with a toggling spike input
    for (int i = 0; i < 3; i++) begin
      spike_in = ~spike_in;
      step();
    end
    chk("rst_isi_valid", int'(isi_valid), 0);
    chk("rst_isi_last", int'(isi_last), 0);
    chk("rst_spike_count", int'(spike_count), 0);
    chk("rst_pattern", int'(pattern), 0);
    chk("rst_win_done", int'(win_done), 0);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      chk("rst_rd_data", int'(rd_data), 0);
    end
    rst_n = 1'b1;
    spike_in = 1'b0;
    rd_sel = 2'd0;

    // Table-driven windows: clear, then exactly one 1000-cycle window
    for (int t = 0; t < 5; t++) begin
      do_clear();
      rd_sel = (scn[t].exp_nshort >= 0) ? 2'd2 : 2'd0;
      for (int c = 0; c < 1000; c++) begin
        spike_in = spike_level(scn[t], c);
        for (int k = 1; k < scn[t].n; k++)
          if (c == int'(scn[t].e[k])) exp_q.push_back(int'(scn[t].e[k]) - int'(scn[t].e[k-1]));
        step();
        if (scn[t].exp_nshort >= 0 && c == 900)
          chk({scn[t].name, "_nshort_live"}, int'(rd_data[5:2]), scn[t].exp_nshort);
        if (c < 999 && win_done) chk({scn[t].name, "_early_win_done"}, c, 999);
      end
      spike_in = 1'b0;
      chk({scn[t].name, "_win_done_count"}, wins, 1);
      chk({scn[t].name, "_isi_pending"}, exp_q.size(), 0);
      exp_q.delete();
      chk({scn[t].name, "_spike_count"}, int'(spike_count), scn[t].exp_cnt);
      chk({scn[t].name, "_pattern"}, int'(pattern), scn[t].exp_pat);
      rd_sel = 2'd0;
      #1;
      chk({scn[t].name, "_rd0"}, int'(rd_data), scn[t].exp_cnt);
      if (scn[t].n >= 2) begin
        int last_isi;
        last_isi = int'(scn[t].e[scn[t].n-1]) - int'(scn[t].e[scn[t].n-2]);
        rd_sel = 2'd3;
        #1;
        chk({scn[t].name, "_rd3"}, int'(rd_data), last_isi % 256);
        rd_sel = 2'd1;
        #1;
        chk({scn[t].name, "_rd1"}, int'(rd_data), last_isi / 16);
      end
      step();
      chk({scn[t].name, "_win_done_1cyc"}, int'(win_done), 0);
    end

    // Mid-window clear after the tonic window: latched results and FSM must reset
    for (int c = 0; c < 30; c++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    wins = 0;
    chk("clr_isi_last", int'(isi_last), 0);
    chk("clr_spike_count", int'(spike_count), 0);
    chk("clr_pattern", int'(pattern), 0);
    rd_sel = 2'd2;
    #1;
    chk("clr_rd2", int'(rd_data), 0);
    rd_sel = 2'd0;
    for (int c = 0; c < 1000; c++) begin
      spike_in = (c == 5 || c == 25);
      if (c == 25) exp_q.push_back(20);
      step();
      if (c == 998) chk("clr_no_partial_win_done", wins, 0);
    end
    spike_in = 1'b0;
    chk("clr_new_win_done", wins, 1);
    chk("clr_spike_count_after", int'(spike_count), 2);
    chk("clr_isi_pending", exp_q.size(), 0);
    exp_q.delete();

    // Enable gating: 40 enabled cycles between edges, 20 frozen cycles with a lost edge
    do_clear();
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    for (int c = 0; c < 10; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      spike_in = (c == 8);
      step();
      if (isi_valid || win_done) chk("dis_pulse", 1, 0);
    end
    spike_in = 1'b0;
    step();
    chk("dis_isi_last_hold", int'(isi_last), 0);
    enable = 1'b1;
    for (int c = 0; c < 29; c++) step();
    spike_in = 1'b1;
    exp_q.push_back(40);
    step();
    spike_in = 1'b0;
    chk("en_isi_valid", int'(isi_valid), 1);
    step();
    chk("en_isi_pending", exp_q.size(), 0);
    exp_q.delete();

    // ISI saturation over 5000 quiet cycles
    do_clear();
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    for (int c = 0; c < 5000; c++) step();
    spike_in = 1'b1;
    exp_q.push_back(4095);
    step();
    spike_in = 1'b0;
    chk("sat_isi_valid", int'(isi_valid), 1);
    rd_sel = 2'd1;
    #1;
    chk("sat_rd1", int'(rd_data), 255);
    step();
    chk("sat_isi_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adex_spike_monitor.md
# adex_spike_monitor

Downstream observer for the AdEx neuron core. It consumes the core's one-cycle spike pulse and measures inter-spike intervals (ISI). It counts spikes per fixed window and classifies the firing pattern per window as none, tonic, adapting or bursting. Results are exposed as registered outputs and through an 8-bit readout mux, so firing statistics can be read without external capture hardware.

## Interface
- `ISI_W`, default 12: ISI counter width; saturates at 2^ISI_W-1.
- `WIN_CYCLES`, default 1000: analysis window length in enabled cycles (≥2).
- `BURST_ISI`, default 8: an ISI strictly below this is "short".

Ports (reset is synchronous, active-low):
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  active-low reset, sampled on the rising `clk` edge.
- `enable`  in  1  monitor enable; low freezes all counters and state.
- `clear`  in  1  synchronous statistics clear.
- `spike_in`  in  1  spike from the neuron core; counted on its rising edge.
- `rd_sel`  in  2  readout field select.
- `rd_data`  out  8  selected readout field.
- `isi_valid`  out  1  one-cycle pulse when `isi_last` updates.
- `isi_last`  out  ISI_W  most recent ISI in cycles.
- `spike_count`  out  8  spike count of the last completed window, saturating at 255.
- `pattern`  out  2  class of the last completed window: 0 none, 1 tonic, 2 adapting, 3 bursting.
- `win_done`  out  1  one-cycle pulse at window close.

## Operation
- **Priority:** `rst_n` low, then `clear`, then `enable`.
- **Reset and clear:** both zero all registers and outputs and set FSM=IDLE. `spike_prev` is still loaded with `spike_in`.
- **Edge detect:** `spike_prev` updates every cycle. `evt = spike_in & ~spike_prev & enable`. A level held high counts once. An edge that occurs while `enable` is low is lost.
- **FSM:**
  - IDLE: no spike seen.
  - FIRST: one spike seen, no ISI yet.
  - TRACK: at least one ISI captured.
  - Transitions: IDLE→FIRST on `evt`; FIRST→TRACK on `evt`; TRACK stays TRACK.
- **ISI counter `isi_cnt`:**
  - On `evt`, loads 1.
  - Otherwise, when enabled and FSM≠IDLE, increments, saturating at 2^ISI_W-1.
  - On `evt` in FIRST or TRACK: `isi_last <= isi_cnt`, `isi_valid <= 1`.
  - The value captured equals the cycle distance between the two rising edges.
- **ISI classification (TRACK only):** each new ISI is classified against `isi_prev`, then `isi_prev <= isi_last`.
  - short: ISI < `BURST_ISI`.
  - else long: ISI > `isi_prev + (isi_prev >> 2)`, compared unsigned at ISI_W+1 bits.
  - else regular.
  - The first ISI after FIRST has no `isi_prev`. It counts only if short, otherwise regular.
  - `n_short`, `n_long` and `n_reg` are 4-bit saturating counts within the window.
- **Window:**
  - `win_cnt` counts enabled cycles from 0 to `WIN_CYCLES`-1.
  - On the terminal cycle, the closing window is latched. An `evt` on that same cycle is included.
  - `spike_count <=` window spike total.
  - `pattern`, in priority order:
    - 0 if total < 2;
    - else 3 if `n_short` ≥ 2;
    - else 2 if `n_long` > `n_reg`;
    - else 1.
  - Window counts then reset to 0. The FSM, `isi_cnt` and `isi_prev` carry over.
- **Readout (combinational from registers):**
  - `rd_sel` 0: `spike_count`.
  - `rd_sel` 1: `isi_last[ISI_W-1:ISI_W-8]`.
  - `rd_sel` 2: `{2'b0, n_short, pattern}`, where `n_short` is the live count.
  - `rd_sel` 3: `isi_last[7:0]`.

## Timing
- All outputs are registered except `rd_data`. Every output resets to 0.
- Edge to `isi_valid`/`isi_last`: 1 cycle after the `evt` cycle. `isi_valid` lasts 1 cycle.
- Terminal window cycle to `win_done`, `spike_count` and `pattern`: 1 cycle. `win_done` lasts 1 cycle.
- `enable` low: no counter advances, pulses stay 0, and all latched outputs hold.
- `clear` or reset mid-window: takes effect next edge with no `win_done` for the partial window. The next window starts at `win_cnt`=0.

## Test plan
Parameters for all scenarios: `WIN_CYCLES`=1000, `BURST_ISI`=8, `ISI_W`=12.

- **Reset:** hold `rst_n` low for 3 cycles with `spike_in` toggling → all outputs 0 and `rd_data`=0 for every `rd_sel`.
- **Tonic:** edges at cycles 10, 60, 110, 160 → three `isi_valid` pulses with `isi_last`=50; at window close, `spike_count`=4, `pattern`=1, `win_done` pulsed once.
- **Adapting:** edges at 100, 130, 170, 225 (ISIs 30, 40, 55, so `n_long`=2 and `n_reg`=1) → `pattern`=2.
- **Bursting and level hold:** edges at 10, 14, 18, 300, 304 with `spike_in` held high 3 cycles each → `spike_count`=5, `pattern`=3, `rd_sel`=2 gives `n_short`=3 before close.
- **Saturation and window boundary:** a spike, 5000 quiet cycles, then a spike → `isi_last`=4095. A spike exactly on a terminal window cycle is counted in the closing window.
- **Clear and enable:**
  - Assert `clear` mid-window → FSM returns to IDLE, counts are 0, and no `win_done` follows.
  - Drop `enable` for 20 cycles between spikes 40 apart → `isi_last`=40 excluding the frozen cycles; an edge during disable is not counted.
